vga_sprite_painter: RTL and testbench

Pixel-colour stage that sits directly downstream of the VGA sync/timing generator. It consumes that generator's pixel enable, counters, blanking and sync signals. It draws a square sprite that bounces off the edges of the 640x480 active area, over a solid background with a one-pixel white frame. Its outputs are 8-bit RGB (3-3-2) and the sync signals, delayed so that pixels and sync stay aligned at the DAC/connector.

---
 rtl/vga_sprite_painter.sv | 109 ++++++++++
 tb/tb_vga_sprite_painter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_painter.sv
// vga_sprite_painter: colours each pixel from the VGA timing generator, drawing a
// bouncing square sprite over a solid background inside a one-pixel white frame.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   pix_en                       pixel strobe (one clk in two)
//   hcount, vcount               current pixel / line from the timing generator
//   blank, hsync_in, vsync_in    blanking and active-low syncs from the generator
//   pause                        freeze sprite motion
//   rgb, hsync, vsync            3-3-2 colour and syncs, all delayed 2 pixels
//   frame_tick                   one-clk pulse per frame
//   bounce_count                 frames containing a bounce, wraps at 256
module vga_sprite_painter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int SIZE = 16,
  parameter int SPEED = 2,
  parameter int X0 = 0,
  parameter int Y0 = 0,
  parameter logic [7:0] FG = 8'hE0,
  parameter logic [7:0] BG = 8'h03,
  parameter logic [7:0] BORDER = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       blank,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       pause,
  output logic [7:0] rgb,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick,
  output logic [7:0] bounce_count
);
  localparam logic [10:0] XMAX = 11'(H_ACTIVE - SIZE);
  localparam logic [10:0] YMAX = 11'(V_ACTIVE - SIZE);
  localparam logic [10:0] SPD = 11'(SPEED);
  localparam logic [10:0] SZ = 11'(SIZE);
  logic [9:0] x_q, x_d, y_q, y_d;
  logic dx_q, dx_d, dy_q, dy_d;
  logic [10:0] nx, ny;
  logic flip_x, flip_y, frame_start;
  logic [7:0] bounce_q, rgb_q;
  logic tick_q, box_q, border_q, blank1_q, hs1_q, vs1_q, hs_q, vs_q;
  assign frame_start = pix_en & (hcount == 10'd0) & (vcount == 10'(V_ACTIVE));
  // Direction bit: 0 = right/down, 1 = left/up. Next position computed with
  // 11-bit headroom so the far-wall compare cannot wrap.
  always_comb begin
    nx = {1'b0, x_q} + SPD;
    ny = {1'b0, y_q} + SPD;
    flip_x = dx_q ? ({1'b0, x_q} <= SPD) : (nx >= XMAX);
    flip_y = dy_q ? ({1'b0, y_q} <= SPD) : (ny >= YMAX);
    x_d = dx_q ? (flip_x ? '0 : x_q - 10'(SPEED)) : (flip_x ? XMAX[9:0] : nx[9:0]);
    y_d = dy_q ? (flip_y ? '0 : y_q - 10'(SPEED)) : (flip_y ? YMAX[9:0] : ny[9:0]);
    dx_d = dx_q ^ flip_x;
    dy_d = dy_q ^ flip_y;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= 10'(X0);
      y_q <= 10'(Y0);
      dx_q <= 1'b0;
      dy_q <= 1'b0;
      bounce_q <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= frame_start;
      if (frame_start && !pause) begin
        x_q <= x_d;
        y_q <= y_d;
        dx_q <= dx_d;
        dy_q <= dy_d;
        bounce_q <= bounce_q + 8'(flip_x | flip_y);
      end
    end
  end
  // Two-stage pixel pipeline; sync copies travel alongside so they stay aligned with rgb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      box_q <= 1'b0;
      border_q <= 1'b0;
      blank1_q <= 1'b1;
      hs1_q <= 1'b1;
      vs1_q <= 1'b1;
      rgb_q <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else if (pix_en) begin
      box_q <= (hcount >= x_q) && ({1'b0, hcount} < {1'b0, x_q} + SZ) &&
               (vcount >= y_q) && ({1'b0, vcount} < {1'b0, y_q} + SZ);
      border_q <= (hcount == 10'd0) || (hcount == 10'(H_ACTIVE - 1)) ||
                  (vcount == 10'd0) || (vcount == 10'(V_ACTIVE - 1));
      blank1_q <= blank;
      hs1_q <= hsync_in;
      vs1_q <= vsync_in;
      rgb_q <= blank1_q ? 8'h00 : border_q ? BORDER : box_q ? FG : BG;
      hs_q <= hs1_q;
      vs_q <= vs1_q;
    end
  end
  assign rgb = rgb_q;
  assign hsync = hs_q;
  assign vsync = vs_q;
  assign frame_tick = tick_q;
  assign bounce_count = bounce_q;
endmodule

// File: tb/tb_vga_sprite_painter.sv
// tb_vga_sprite_painter: random pixel probes scored against a frame-level sprite model.
module tb_vga_sprite_painter;
  logic clk = 1'b0, rst_n = 1'b0, pix_en = 1'b0, blank = 1'b1;
  logic hsync_in = 1'b1, vsync_in = 1'b1, pause = 1'b0;
  logic [9:0] hcount = '0, vcount = '0;
  logic [7:0] rgb, bounce_count, rgb2, bc2;
  logic hsync, vsync, frame_tick, hs2, vs2, ft2;
  typedef struct {logic [7:0] rgb; logic hs; logic vs;} exp_t;
  exp_t sbq[$];
  int checks = 0, failures = 0;
  int xm, ym, dxm, dym, bm, x2, y2, dx2, dy2, b2;
  vga_sprite_painter dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
    .blank(blank), .hsync_in(hsync_in), .vsync_in(vsync_in), .pause(pause),
    .rgb(rgb), .hsync(hsync), .vsync(vsync), .frame_tick(frame_tick),
    .bounce_count(bounce_count)
  );
  // Square 480x480 variant: both axes hit their walls on the same frame (corner bounce).
  vga_sprite_painter #(.H_ACTIVE(480)) dut2 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
    .blank(blank), .hsync_in(hsync_in), .vsync_in(vsync_in), .pause(pause),
    .rgb(rgb2), .hsync(hs2), .vsync(vs2), .frame_tick(ft2), .bounce_count(bc2)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic move(inout int p, inout int d, input int lim, output bit f);
    f = 0;
    if (d == 0) begin
      if (p + 2 >= lim - 16) begin p = lim - 16; d = 1; f = 1; end
      else p = p + 2;
    end else begin
      if (p <= 2) begin p = 0; d = 0; f = 1; end
      else p = p - 2;
    end
  endtask
  function automatic logic [7:0] color(int h, int v);
    if (h == 0 || h == 639 || v == 0 || v == 479) return 8'hFF;
    if (h >= xm && h < xm + 16 && v >= ym && v < ym + 16) return 8'hE0;
    return 8'h03;
  endfunction
  task automatic model_reset();
    xm = 0; ym = 0; dxm = 0; dym = 0; bm = 0;
    x2 = 0; y2 = 0; dx2 = 0; dy2 = 0; b2 = 0;
  endtask
  task automatic pix(input int h, input int v, input bit b, input bit hs, input bit vs);
    bit fs, f1, f2;
    exp_t e;
    hcount = 10'(h); vcount = 10'(v); blank = b; hsync_in = hs; vsync_in = vs; pix_en = 1'b1;
    e.rgb = b ? 8'h00 : color(h, v);
    e.hs = hs;
    e.vs = vs;
    sbq.push_back(e);
    fs = (h == 0 && v == 480);
    @(posedge clk);
    #1;
    if (fs) begin
      if (!pause) begin
        move(xm, dxm, 640, f1);
        move(ym, dym, 480, f2);
        if (f1 || f2) bm = (bm + 1) % 256;
        move(x2, dx2, 480, f1);
        move(y2, dy2, 480, f2);
        if (f1 || f2) b2 = (b2 + 1) % 256;
      end
      chk("frame_tick_pulse", frame_tick, 1);
      chk("bounce_count", bounce_count, bm);
      chk("bounce_count_square", bc2, b2);
    end else chk("frame_tick_idle", frame_tick, 0);
    pix_en = 1'b0;
    hcount = 10'($urandom); vcount = 10'($urandom);
    blank = 1'($urandom); hsync_in = 1'($urandom); vsync_in = 1'($urandom);
    @(posedge clk);
    #1;
    chk("frame_tick_clear", frame_tick, 0);
  endtask
  task automatic frame();
    pix(0, 480, 1, 1, 0);
  endtask
  task automatic probe(input int n);
    int h, v;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        h = xm + $urandom_range(0, 21) - 3;
        v = ym + $urandom_range(0, 21) - 3;
        h = h < 0 ? 0 : h > 639 ? 639 : h;
        v = v < 0 ? 0 : v > 479 ? 479 : v;
      end else begin
        h = $urandom_range(0, 799);
        v = $urandom_range(0, 524);
      end
      if (h == 0 && v == 480) h = 1;
      pix(h, v, (h >= 640 || v >= 480 || $urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom));
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (pix_en && rst_n) begin
        #1;
        if (sbq.size() >= 2) begin
          e = sbq.pop_front();
          chk("rgb", rgb, e.rgb);
          chk("hsync", hsync, e.hs);
          chk("vsync", vsync, e.vs);
        end
      end
    end
  end
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rgb", rgb, 0);
    chk("reset_hsync", hsync, 1);
    chk("reset_vsync", vsync, 1);
    chk("reset_frame_tick", frame_tick, 0);
    chk("reset_bounce", bounce_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    frame();
    for (int h = 0; h < 22; h++) pix(h, 10, 0, 1, 1);
    for (int h = 636; h < 644; h++) pix(h, 10, h >= 640, 1, 1);
    for (int f = 0; f < 800; f++) begin
      pause = ($urandom_range(0, 7) == 0);
      frame();
      pause = 1'b0;
      probe(4);
    end
    pause = 1'b1;
    repeat (3) begin frame(); probe(3); end
    pause = 1'b0;
    for (int h = 0; h < 800; h++)
      pix(h, 100, h >= 640, !(h >= 656 && h < 752), 1);
    pix_en = 1'b0; hcount = 10'd0; vcount = 10'd480;
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("stuck_frame_tick", frame_tick, 0);
    end
    chk("stuck_bounce", bounce_count, bm);
    for (int h = 0; h < 6; h++) pix(h, 200, 0, 1, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rgb", rgb, 0);
    chk("async_hsync", hsync, 1);
    chk("async_vsync", vsync, 1);
    chk("async_bounce", bounce_count, 0);
    sbq.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    probe(12);
    frame();
    probe(12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
